nibble_serial_add_arb: RTL and testbench

NIBBLE_SERIAL_ADD_ARB -- requirements
Module: nibble_serial_add_arb

---
 rtl/nibble_serial_add_arb_pkg.sv | 17 +
 rtl/nibble_serial_add_arb_nibble_full_adder.sv | 25 ++
 rtl/nibble_serial_add_arb.sv | 157 +++++++++++++++
 tb/tb_nibble_serial_add_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_add_arb_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial adder arbiter.
package nibble_serial_add_arb_pkg;

   // Width of one serial add step.
   localparam int NIBBLE_W = 4;

   // Nibble counter width: covers indices 0..7 (NIBBLES up to 8).
   localparam int CNT_W = 3;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_add_arb_nibble_full_adder.sv
// Combinational 4-bit ripple-carry adder built from 1-bit full-add cells.
module nibble_full_adder
   import nibble_serial_add_arb_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);

   // c[i] is the carry into bit i; c[NIBBLE_W] leaves the nibble.
   logic [NIBBLE_W:0] c;

   assign c[0] = cin;

   // One full-add cell per bit, carry rippling upward.
   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_cell
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_arb.sv
// Two-requester round-robin arbiter in front of a nibble-serial adder.
//
// Handshakes:
//   req/gnt  : a requester holds req[i] (and its operands) until it sees a
//              one-cycle gnt[i]; operands are captured on that clock edge.
//   done/ack : done stays high with sum/cout/done_id stable until the
//              consumer raises done_ack; the unit returns to IDLE on the
//              following edge and may grant again in that same IDLE cycle.
module nibble_serial_add_arb
   import nibble_serial_add_arb_pkg::*;
#(
   parameter int NIBBLES = 4
)
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [1:0]                    req,
   input  logic [NIBBLE_W*NIBBLES-1:0]   x0,
   input  logic [NIBBLE_W*NIBBLES-1:0]   y0,
   input  logic [NIBBLE_W*NIBBLES-1:0]   x1,
   input  logic [NIBBLE_W*NIBBLES-1:0]   y1,
   output logic [1:0]                    gnt,
   output logic                          busy,
   output logic                          done,
   output logic                          done_id,
   output logic [NIBBLE_W*NIBBLES-1:0]   sum,
   output logic                          cout,
   input  logic                          done_ack,
   output logic [1:0]                    dbg_state
);

   localparam int W = NIBBLE_W * NIBBLES;

   state_t state;
   state_t state_nxt;

   // Operand shift registers: the nibble being added is always at the bottom.
   logic [W-1:0]       x_q;
   logic [W-1:0]       y_q;
   // Result assembles from the top down so nibble 0 ends up at the bottom.
   logic [W-1:0]       sum_q;
   logic               carry_q;
   logic               cout_q;
   logic               id_q;
   // Round-robin pointer: id of the requester granted most recently.
   logic               last_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [1:0]         gnt_c;
   logic               win_id;
   logic               last_nib;
   logic [NIBBLE_W-1:0] nib_s;
   logic               nib_c;

   assign last_nib = (cnt_q == CNT_W'(NIBBLES - 1));

   nibble_full_adder u_nibble_full_adder (
      .a    (x_q[NIBBLE_W-1:0]),
      .b    (y_q[NIBBLE_W-1:0]),
      .cin  (carry_q),
      .s    (nib_s),
      .cout (nib_c)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and round-robin grant; the grant is suppressed during reset.
   always_comb begin
      state_nxt = state;
      gnt_c     = 2'b00;
      win_id    = 1'b0;
      case (state)
         IDLE: begin
            if (rst_n && (req != 2'b00)) begin
               if (req == 2'b11) begin
                  win_id = ~last_q;
               end else begin
                  win_id = req[1];
               end
               gnt_c     = win_id ? 2'b10 : 2'b01;
               state_nxt = ADD;
            end
         end
         ADD: begin
            if (last_nib) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (done_ack) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: capture on grant, one nibble per ADD cycle, hold in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_c != 2'b00) begin
                  x_q     <= win_id ? x1 : x0;
                  y_q     <= win_id ? y1 : y0;
                  id_q    <= win_id;
                  last_q  <= win_id;
                  sum_q   <= '0;
                  carry_q <= 1'b0;
                  cout_q  <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            ADD: begin
               sum_q   <= {nib_s, sum_q[W-1:NIBBLE_W]};
               x_q     <= x_q >> NIBBLE_W;
               y_q     <= y_q >> NIBBLE_W;
               carry_q <= nib_c;
               if (last_nib) begin
                  cout_q <= nib_c;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign gnt       = gnt_c;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign done_id   = id_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_nibble_serial_add_arb.sv
// Directed bench: a 16-bit instance driven from a vector table plus
// hand sequences, and an 8-bit instance for the short-operand case.
module tb_nibble_serial_add_arb;

  localparam int NIB  = 4;
  localparam int W    = 4 * NIB;
  localparam int NIB2 = 2;
  localparam int W2   = 4 * NIB2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic [1:0]   req = 2'b00;
  logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic         done_ack = 1'b0;
  logic [1:0]   gnt;
  logic         busy, done, done_id, cout;
  logic [W-1:0] sum;
  logic [1:0]   dbg_state;

  // 8-bit instance
  logic [1:0]    req_b = 2'b00;
  logic [W2-1:0] x0_b = '0, y0_b = '0, x1_b = '0, y1_b = '0;
  logic          done_ack_b = 1'b0;
  logic [1:0]    gnt_b;
  logic          busy_b, done_b, done_id_b, cout_b;
  logic [W2-1:0] sum_b;
  logic [1:0]    dbg_state_b;

  nibble_serial_add_arb #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .sum(sum), .cout(cout), .done_ack(done_ack), .dbg_state(dbg_state)
  );

  nibble_serial_add_arb #(.NIBBLES(NIB2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .x0(x0_b), .y0(y0_b), .x1(x1_b), .y1(y1_b),
    .gnt(gnt_b), .busy(busy_b), .done(done_b), .done_id(done_id_b),
    .sum(sum_b), .cout(cout_b), .done_ack(done_ack_b), .dbg_state(dbg_state_b)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]   req;
    logic [W-1:0] x0, y0, x1, y1;
    logic [1:0]   exp_gnt;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_id;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt();
    int cyc;
    cyc = 0;
    while (gnt == 2'b00 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  // Called in the grant cycle; returns the cycle count until done is seen.
  task automatic wait_done(output int lat);
    tick();
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic ack_and_check(input string name);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    check({name, "_idle_after_ack"}, 32'({busy, done}), 32'b00);
  endtask

  // Full transaction from one table record.
  task automatic run_op(input vec_t v, input int idx);
    int lat;
    string tag;
    logic [W-1:0] exp_sum;
    tag = $sformatf("vec%0d", idx);
    tick();
    req = v.req; x0 = v.x0; y0 = v.y0; x1 = v.x1; y1 = v.y1;
    #1;
    wait_gnt();
    check({tag, "_gnt"}, 32'(gnt), 32'(v.exp_gnt));
    exp_q.push_back(v.exp_sum);
    wait_done(lat);
    req = 2'b00;
    check({tag, "_latency"}, 32'(lat), 32'(NIB + 1));
    exp_sum = exp_q.pop_front();
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(v.exp_cout));
    check({tag, "_done_id"}, 32'(done_id), 32'(v.exp_id));
    check({tag, "_gnt_in_done"}, 32'(gnt), 32'(2'b00));
    ack_and_check(tag);
  endtask

  initial begin
    int lat;
    int seen_done;
    logic [1:0] exp_g[3];
    logic [W-1:0] exp_s[3];

    //            req    x0       y0       x1       y1       gnt    sum      cout  id
    tbl[0] = '{2'b01, 16'h1234, 16'h1111, 16'h9999, 16'h9999, 2'b01, 16'h2345, 1'b0, 1'b0};
    tbl[1] = '{2'b10, 16'h9999, 16'h9999, 16'hFFFF, 16'h0001, 2'b10, 16'h0000, 1'b1, 1'b1};
    tbl[2] = '{2'b11, 16'h00FF, 16'h0001, 16'h5555, 16'h5555, 2'b01, 16'h0100, 1'b0, 1'b0};
    tbl[3] = '{2'b11, 16'h1111, 16'h1111, 16'h8000, 16'h8000, 2'b10, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{2'b01, 16'hABCD, 16'h1234, 16'h0000, 16'h0000, 2'b01, 16'hBE01, 1'b0, 1'b0};
    tbl[5] = '{2'b10, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 2'b10, 16'hFFFE, 1'b1, 1'b1};
    tbl[6] = '{2'b11, 16'h7FFF, 16'h0001, 16'hF0F0, 16'h0F0F, 2'b01, 16'h8000, 1'b0, 1'b0};

    // reset values
    #1;
    check("reset_outputs", 32'({gnt, busy, done, done_id, cout, dbg_state}), 32'(0));
    check("reset_sum", 32'(sum), 32'(0));
    check("reset_outputs_b", 32'({gnt_b, busy_b, done_b, sum_b}), 32'(0));
    tick();
    rst_n = 1'b1;

    // table-driven transactions
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i], i);
    end

    // both requesting from reset: 01, 10, 01 with no idle bubble
    rst_n = 1'b0;
    req = 2'b11;
    x0 = 16'h0001; y0 = 16'h0002; x1 = 16'h0010; y1 = 16'h0020;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    exp_s[0] = 16'h0003; exp_s[1] = 16'h0030; exp_s[2] = 16'h0003;
    tick();
    check("gnt_held_in_reset", 32'(gnt), 32'(2'b00));
    rst_n = 1'b1;
    #1;
    check("gnt_first_cycle_after_reset", 32'(gnt), 32'(2'b01));
    for (int k = 0; k < 3; k++) begin
      wait_gnt();
      check($sformatf("tie_gnt%0d", k), 32'(gnt), 32'(exp_g[k]));
      wait_done(lat);
      check($sformatf("tie_sum%0d", k), 32'(sum), 32'(exp_s[k]));
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
      check($sformatf("tie_no_bubble%0d", k), 32'(gnt != 2'b00), 32'(1));
    end
    req = 2'b00;
    tick();
    tick();
    ack_and_check("tie_tail");

    // done held without ack; a pending request waits until the ack
    tick();
    req = 2'b01; x0 = 16'h0F0F; y0 = 16'h0101; x1 = 16'h2222; y1 = 16'h3333;
    #1;
    wait_gnt();
    check("hold_gnt0", 32'(gnt), 32'(2'b01));
    tick();
    req = 2'b10;
    while (!done) tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold_state%0d", k), 32'({done, busy, gnt, cout}), 32'({1'b1, 1'b1, 2'b00, 1'b0}));
      check($sformatf("hold_sum%0d", k), 32'(sum), 32'(16'h1010));
      tick();
    end
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    check("hold_ack_idle", 32'({busy, done}), 32'b00);
    check("hold_next_gnt", 32'(gnt), 32'(2'b10));
    tick();
    req = 2'b00;
    // ack raised during ADD must not disturb the operation
    done_ack = 1'b1;
    tick();
    tick();
    done_ack = 1'b0;
    seen_done = 0;
    while (!done && seen_done < 20) begin
      tick();
      seen_done++;
    end
    check("ack_in_add_ignored", 32'({done, sum}), 32'({1'b1, 16'h5555}));
    check("hold_done_id", 32'(done_id), 32'(1));
    ack_and_check("hold");

    // reset during the second ADD cycle
    tick();
    req = 2'b10; x1 = 16'h1234; y1 = 16'h4321;
    #1;
    wait_gnt();
    tick();
    req = 2'b00;
    tick();
    check("mid_add_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", 32'({gnt, busy, done, done_id, cout}), 32'(0));
    check("mid_reset_sum", 32'(sum), 32'(0));
    tick();
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) seen_done++;
    end
    check("no_done_after_reset", 32'(seen_done), 32'(0));
    // pointer reset: tie goes to requester 0 again
    run_op('{2'b11, 16'h0F00, 16'h0100, 16'h1234, 16'h4321, 2'b01, 16'h1000, 1'b0, 1'b0}, 7);

    // two-nibble instance with carry out of both nibbles
    tick();
    req_b = 2'b01; x0_b = 8'h8F; y0_b = 8'h81;
    #1;
    check("b_gnt", 32'(gnt_b), 32'(2'b01));
    tick();
    req_b = 2'b00;
    lat = 1;
    while (!done_b && lat < 40) begin
      tick();
      lat++;
    end
    check("b_latency", 32'(lat), 32'(NIB2 + 1));
    check("b_sum", 32'(sum_b), 32'(8'h10));
    check("b_cout", 32'(cout_b), 32'(1));
    done_ack_b = 1'b1;
    tick();
    done_ack_b = 1'b0;
    check("b_idle_after_ack", 32'({busy_b, done_b}), 32'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
